// File: rtl/nibble_serial_adder.sv
// Multi-cycle W-bit adder that sequences an external 4-bit adder one nibble per clock.
// Operands are captured on start; SUM/Cout are presented with a one-cycle done pulse.
module nibble_serial_adder #(
    parameter int NIBBLES = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [4*NIBBLES-1:0] X,
    input  logic [4*NIBBLES-1:0] Y,
    input  logic                 Cin,
    output logic                 busy,
    output logic                 done,
    output logic [4*NIBBLES-1:0] SUM,
    output logic                 Cout,
    output logic [3:0]           add_A,
    output logic [3:0]           add_B,
    output logic                 add_Cin,
    input  logic [3:0]           add_S,
    input  logic                 add_Cout
);
    localparam int W = 4 * NIBBLES;
    localparam logic [3:0] LAST = 4'(NIBBLES - 1);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t         state_q, state_d;
    logic [W-1:0]   xr_q, xr_d;
    logic [W-1:0]   yr_q, yr_d;
    logic [W-1:0]   sum_q, sum_d;
    logic           carry_q, carry_d;
    logic           cout_q, cout_d;
    logic [3:0]     idx_q, idx_d;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            xr_q    <= '0;
            yr_q    <= '0;
            sum_q   <= '0;
            carry_q <= 1'b0;
            cout_q  <= 1'b0;
            idx_q   <= '0;
        end else begin
            state_q <= state_d;
            xr_q    <= xr_d;
            yr_q    <= yr_d;
            sum_q   <= sum_d;
            carry_q <= carry_d;
            cout_q  <= cout_d;
            idx_q   <= idx_d;
        end
    end

    always_comb begin
        state_d = state_q;
        xr_d    = xr_q;
        yr_d    = yr_q;
        sum_d   = sum_q;
        carry_d = carry_q;
        cout_d  = cout_q;
        idx_d   = idx_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    xr_d    = X;
                    yr_d    = Y;
                    carry_d = Cin;
                    idx_d   = '0;
                    sum_d   = '0;
                    cout_d  = 1'b0;
                    state_d = RUN;
                end
            end
            RUN: begin
                for (int n = 0; n < NIBBLES; n++) begin
                    if (idx_q == 4'(n)) sum_d[4*n +: 4] = add_S;
                end
                carry_d = add_Cout;
                if (idx_q == LAST) begin
                    cout_d  = add_Cout;
                    state_d = DONE;
                end else begin
                    idx_d = idx_q + 4'd1;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Adder operands come from registers only, and are forced to zero outside RUN.
    always_comb begin
        add_A   = 4'd0;
        add_B   = 4'd0;
        add_Cin = 1'b0;
        if (state_q == RUN) begin
            for (int n = 0; n < NIBBLES; n++) begin
                if (idx_q == 4'(n)) begin
                    add_A = xr_q[4*n +: 4];
                    add_B = yr_q[4*n +: 4];
                end
            end
            add_Cin = carry_q;
        end
    end

    assign busy = (state_q != IDLE);
    assign done = (state_q == DONE);
    assign SUM  = sum_q;
    assign Cout = cout_q;
endmodule

// File: tb/tb_nibble_serial_adder.sv
// Scoreboard bench for nibble_serial_adder (NIBBLES=4) with a behavioural 4-bit adder attached.
module tb_nibble_serial_adder;
    localparam int N = 4;
    localparam int W = 4 * N;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         start = 1'b0;
    logic [W-1:0] X = '0, Y = '0;
    logic         Cin = 1'b0;
    logic         busy, done, Cout, add_Cin, add_Cout;
    logic [W-1:0] SUM;
    logic [3:0]   add_A, add_B, add_S;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    logic [W:0] exp_q[$];
    logic [3:0] aseq[$];
    int         done_cyc[$];

    nibble_serial_adder #(.NIBBLES(N)) dut (
        .clk(clk), .rst(rst), .start(start), .X(X), .Y(Y), .Cin(Cin),
        .busy(busy), .done(done), .SUM(SUM), .Cout(Cout),
        .add_A(add_A), .add_B(add_B), .add_Cin(add_Cin),
        .add_S(add_S), .add_Cout(add_Cout)
    );

    assign {add_Cout, add_S} = {1'b0, add_A} + {1'b0, add_B} + {4'd0, add_Cin};

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [W:0] act, input logic [W:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, req);
        end
    endtask

    // Monitor: pops the scoreboard on done and polices the adder-port gating.
    always @(negedge clk) begin
        if (!rst) begin
            if (busy && !done) aseq.push_back(add_A);
            if (!busy || done)
                chk("add_idle_zero", {8'd0, add_A, add_B, add_Cin}, '0);
            if (done) begin
                done_cyc.push_back(cyc);
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_done: got SUM=%h Cout=%b with empty scoreboard", SUM, Cout);
                end else begin
                    chk("result", {Cout, SUM}, exp_q.pop_front());
                end
            end
        end
    end

    // One operation: drive on a negedge, accept at next posedge, time the done pulse.
    task automatic do_op(input logic [W-1:0] x, input logic [W-1:0] y, input logic c,
                         input logic [W:0] exp, input bit interfere);
        int lat;
        @(negedge clk);
        X = x; Y = y; Cin = c; start = 1'b1;
        exp_q.push_back(exp);
        @(posedge clk);
        #1 start = 1'b0;
        lat = 0;
        for (int k = 1; k <= 20; k++) begin
            @(negedge clk);
            if (k == 1) begin
                chk("busy_after_start", {16'd0, busy}, 17'd1);
                chk("sum_cleared", {Cout, SUM}, '0);
            end
            if (interfere && k == 2) begin
                X = 16'hAAAA; Y = 16'h5555; Cin = 1'b1; start = 1'b1;
            end
            if (interfere && k == 3) start = 1'b0;
            if (done) begin
                lat = k;
                break;
            end
        end
        if (lat == 0) begin
            checks++;
            errors++;
            $display("FAIL done_timeout: got no done within 20 cycles, expected %0d", N + 1);
        end else begin
            chk("latency", 17'(lat), 17'(N + 1));
        end
    endtask

    initial begin
        // Reset state
        #12;
        chk("rst_outputs", {busy, done, Cout, SUM}, '0);
        chk("rst_add", {8'd0, add_A, add_B, add_Cin}, '0);
        @(negedge clk);
        rst = 1'b0;

        // Test 1: basic + add_A sequence
        aseq.delete();
        do_op(16'h1234, 16'h4321, 1'b0, 17'h05555, 0);
        chk("aseq_len", 17'(aseq.size()), 17'd4);
        if (aseq.size() == 4)
            chk("aseq", {1'b0, aseq[0], aseq[1], aseq[2], aseq[3]}, {1'b0, 16'h4321});

        // Test 2: ripple carries
        do_op(16'hFFFF, 16'h0001, 1'b0, 17'h10000, 0);
        do_op(16'hFFFF, 16'hFFFF, 1'b1, 17'h1FFFF, 0);

        // Test 3: start pulse during RUN is ignored
        do_op(16'h0102, 16'h0304, 1'b0, 17'h00406, 1);
        repeat (8) @(negedge clk);
        chk("no_extra_done", 17'(exp_q.size()), 17'd0);
        chk("hold_after_done", {Cout, SUM}, 17'h00406);

        // Test 4: start held high -> one result every N+2 cycles
        done_cyc.delete();
        @(negedge clk);
        X = 16'h8001; Y = 16'h8002; Cin = 1'b1; start = 1'b1;
        repeat (3) exp_q.push_back(17'h10004);
        for (int r = 0; r < 3; r++) begin
            for (int k = 0; k < 20 && !done; k++) @(negedge clk);
            if (!done) begin
                checks++;
                errors++;
                $display("FAIL held_timeout: got no done in op %0d, expected done", r);
                break;
            end
            if (r == 2) begin
                start = 1'b0;
                @(negedge clk);
            end else begin
                @(negedge clk);
                chk("held_idle_hold", {Cout, SUM}, 17'h10004);
                @(negedge clk);
                chk("held_reaccept_clear", {busy, SUM}, {1'b1, 16'h0});
            end
        end
        if (done_cyc.size() == 3) begin
            chk("period0", 17'(done_cyc[1] - done_cyc[0]), 17'(N + 2));
            chk("period1", 17'(done_cyc[2] - done_cyc[1]), 17'(N + 2));
        end else begin
            checks++;
            errors++;
            $display("FAIL held_count: got %0d dones, expected 3", done_cyc.size());
        end

        // Test 5: async reset mid-RUN
        @(negedge clk);
        X = 16'h1111; Y = 16'h2222; Cin = 1'b0; start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        @(posedge clk);
        #2 rst = 1'b1;
        #1;
        chk("async_rst_out", {busy, done, Cout, SUM}, '0);
        chk("async_rst_add", {8'd0, add_A, add_B, add_Cin}, '0);
        @(negedge clk);
        rst = 1'b0;
        do_op(16'h00FF, 16'h0F01, 1'b1, 17'h01001, 0);

        // Test 6: randomized operations against X+Y+Cin
        for (int i = 0; i < 500; i++) begin
            logic [W-1:0] rx, ry;
            logic rc;
            rx = 16'($urandom);
            ry = 16'($urandom);
            rc = 1'($urandom);
            do_op(rx, ry, rc, {1'b0, rx} + {1'b0, ry} + {16'd0, rc}, 0);
        end

        repeat (3) @(negedge clk);
        chk("scoreboard_empty", 17'(exp_q.size()), 17'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/nibble_serial_adder.md
# nibble_serial_adder

Multi-cycle adder for operands of 4×NIBBLES bits. It produces the sum one nibble per clock through an external adder4bit instance. The block acts as that adder's sequencer: it drives the adder's A/B/Cin inputs from its operand registers and consumes S/Cout back into a result register and a carry register. A start/busy/done handshake presents the result to downstream logic.

## Interface
- NIBBLES, default 4: number of 4-bit slices; operand width W = 4*NIBBLES; legal range 1–16.
- clk  in  1  single clock; all state changes on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  request; sampled only in IDLE.
- X  in  W  operand X; sampled with start.
- Y  in  W  operand Y; sampled with start.
- Cin  in  1  carry-in; sampled with start.
- busy  out  1  high in RUN and DONE.
- done  out  1  one-cycle pulse; SUM and Cout are valid while it is high.
- SUM  out  W  result register.
- Cout  out  1  final carry-out register.
- add_A  out  4  to adder4bit A.
- add_B  out  4  to adder4bit B.
- add_Cin  out  1  to adder4bit Cin.
- add_S  in  4  from adder4bit S.
- add_Cout  in  1  from adder4bit Cout.

## Operation
- Internal registers:
  - Xr, Yr (W bits).
  - carry (1 bit).
  - idx (4 bits).
  - state ∈ {IDLE, RUN, DONE}.
- IDLE:
  - start=1 at an edge: Xr←X, Yr←Y, carry←Cin, idx←0, SUM←0, Cout←0, state←RUN.
  - start=0: hold.
- RUN:
  - add_A = Xr[4*idx+3:4*idx], add_B = Yr[4*idx+3:4*idx], add_Cin = carry. All are driven combinationally from registers only, with no path from start, X, or Y.
  - At each edge: SUM[4*idx+3:4*idx]←add_S, carry←add_Cout.
  - If idx = NIBBLES−1: Cout←add_Cout, state←DONE. Otherwise idx←idx+1.
- DONE: done=1 for this cycle, then state←IDLE unconditionally.
- add_A, add_B and add_Cin are 0 whenever state ≠ RUN.
- start is ignored in RUN and DONE; it is not queued. A start held high through DONE is accepted on the first IDLE edge.
- SUM and Cout hold their values from DONE until the next accepted start. On the next accepted start they clear to 0.
- Arithmetic: {Cout,SUM} = X + Y + Cin, full W+1-bit result with no saturation. Wrap-around shows only as Cout=1.
- The block relies only on the adder being combinational and settling within one clock. It contains no adder logic of its own.

## Timing
- Reset (asynchronous, any state, including mid-RUN): state=IDLE, idx=0, carry=0, Xr=Yr=0, SUM=0, Cout=0, busy=0, done=0, add_A/add_B/add_Cin=0. The in-progress operation is discarded. The first start is accepted at the first rising edge after rst deasserts.
- Start accepted at edge E0.
  - Nibble k is written at edge E0+1+k.
  - done is high in the cycle after edge E0+NIBBLES, i.e. between edges E0+NIBBLES and E0+NIBBLES+1.
  - Latency from start edge to done = NIBBLES+1 cycles.
  - Minimum start-to-start interval = NIBBLES+2 cycles.
- busy rises after E0 and falls after edge E0+NIBBLES+1, together with done.
- Intermediate SUM nibbles are visible during RUN but are not valid until done.
- NIBBLES=1: RUN lasts one cycle and done follows at E0+2.

## Test plan
1. NIBBLES=4, X=0x1234, Y=0x4321, Cin=0 → done 5 cycles after the start edge, SUM=0x5555, Cout=0; add_A sequence 4,3,2,1 during RUN.
2. X=0xFFFF, Y=0x0001, Cin=0 → the carry ripples through every nibble: SUM=0x0000, Cout=1. Also X=0xFFFF, Y=0xFFFF, Cin=1 → SUM=0xFFFF, Cout=1.
3. Start pulses during RUN with different X and Y → ignored; the result matches the first operands and done pulses exactly once.
4. start held high continuously with fixed operands → one result every 6 cycles; done high for one cycle each time; SUM clears to 0 on each re-accept.
5. rst asserted asynchronously mid-RUN, between edges → all outputs 0 immediately. After release, X=0x00FF, Y=0x0F01, Cin=1 → SUM=0x1001, Cout=0.
6. Randomized 500 operations against a reference X+Y+Cin, with adder4bit connected → zero mismatches; add_* are 0 whenever busy=0 or done=1.
